// File: rtl/div.sv
// rtl/div.sv - 32-bit signed/unsigned radix-2 restoring divider with annul support
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [64:0] acc;
    logic [31:0] dvs;
    logic [31:0] dvd_raw;
    logic        neg_quo;
    logic        neg_rem;
    logic        by_zero;

    logic        accept;
    logic        is_zero;
    logic        is_ovf;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        trial_ge;
    logic [31:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept  = (start_i == DivStart) && !annul_i;
    assign is_zero = (opdata2_i == 32'd0);
    assign is_ovf  = signed_div_i && (opdata1_i == 32'h8000_0000) && (opdata2_i == 32'hFFFF_FFFF);
    assign mag1    = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign mag2    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // The shifted partial remainder acc[64:32] is 33 bits wide, so divisors
    // above 2^31 still compare correctly; on success the difference fits in 32.
    assign trial_ge = acc[64:32] >= {1'b0, dvs};
    assign diff     = acc[63:32] - dvs;

    assign quo_fix = neg_quo ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix = neg_rem ? (~acc[64:33] + 32'd1) : acc[64:33];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (is_zero || is_ovf) ? BYZERO : ON;
                end
            end
            BYZERO: state_nxt = annul_i ? FREE : END;
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (cnt == 6'd32) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (start_i == DivStop) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            acc      <= 65'd0;
            dvs      <= 32'd0;
            dvd_raw  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            by_zero  <= 1'b0;
            ready_o  <= DivResultNotReady;
            result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= 64'd0;
                    if (accept) begin
                        cnt     <= 6'd0;
                        acc     <= {32'd0, mag1, 1'b0};
                        dvs     <= mag2;
                        dvd_raw <= opdata1_i;
                        neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem <= signed_div_i && opdata1_i[31];
                        by_zero <= is_zero;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        ready_o  <= DivResultNotReady;
                        result_o <= 64'd0;
                    end else begin
                        ready_o  <= DivResultReady;
                        result_o <= by_zero ? {dvd_raw, 32'hFFFF_FFFF} : {32'd0, 32'h8000_0000};
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt      <= 6'd0;
                        ready_o  <= DivResultNotReady;
                        result_o <= 64'd0;
                    end else if (cnt != 6'd32) begin
                        acc <= trial_ge ? {diff, acc[31:0], 1'b1} : {acc[63:0], 1'b0};
                        cnt <= cnt + 6'd1;
                    end else begin
                        cnt      <= 6'd0;
                        ready_o  <= DivResultReady;
                        result_o <= {rem_fix, quo_fix};
                    end
                end
                END: begin
                    if (start_i == DivStop) begin
                        ready_o  <= DivResultNotReady;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - randomized self-checking bench for div against a behavioural model
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 busy (m_left edges to go), 2 holding a result.
    int          m_mode = 0;
    int          m_left = 0;
    logic [63:0] m_res = 64'd0;
    logic        m_ready = 1'b0;
    logic [63:0] m_out = 64'd0;
    bit          m_valid = 1'b0;

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step;
        bit special;
        if (rst) begin
            m_mode  = 0;
            m_ready = 1'b0;
            m_out   = 64'd0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                0: if (start_i && !annul_i) begin
                    special = (opdata2_i == 32'd0) ||
                              (signed_div_i && opdata1_i == 32'h8000_0000 && opdata2_i == 32'hFFFF_FFFF);
                    m_res  = ref_div(signed_div_i, opdata1_i, opdata2_i);
                    m_left = special ? 1 : 33;
                    m_mode = 1;
                end
                1: if (annul_i) begin
                    m_mode = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode  = 2;
                        m_ready = 1'b1;
                        m_out   = m_res;
                    end
                end
                default: if (!start_i) begin
                    m_mode  = 0;
                    m_ready = 1'b0;
                    m_out   = 64'd0;
                end
            endcase
        end
    endtask

    // One clock: model sees the inputs at the rising edge, outputs compared at the falling edge.
    task automatic tick;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) begin
            check("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
            check("result_o", result_o, m_out);
        end
    endtask

    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int annul_at, input int rst_at,
                          input bit drop, input bit chg,
                          output int lat, output logic [63:0] res);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        lat          = -1;
        res          = 64'd0;
        for (int e = 0; e < 40; e++) begin
            if (e == annul_at) annul_i = 1'b1;
            if (e == rst_at) rst = 1'b1;
            if (drop && e == 4) start_i = 1'b0;
            if (drop && e == 12) start_i = 1'b1;
            tick();
            annul_i = 1'b0;
            rst     = 1'b0;
            if (chg && e == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (e == annul_at || e == rst_at) break;
            if (ready_o) begin
                lat = e;
                res = result_o;
                break;
            end
        end
        if (lat >= 0) begin
            repeat (hold) tick();
            check("hold_stable", result_o, res);
        end else if (annul_at < 0 && rst_at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no ready_o within 40 edges expected ready_o=1");
        end
        start_i = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        logic [63:0] res;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        tick();
        tick();
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        check("pin_u_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check("pin_s_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check("pin_s_7_m2", ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), 64'h00000001_FFFFFFFD);
        check("pin_u_ovf", ref_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF), 64'h80000000_00000000);

        // First edge after reset release must accept the request.
        run_op(1'b0, 32'd100, 32'd7, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_100_7", 64'(lat), 64'd33);
        check("res_100_7", res, 64'h00000002_0000000E);
        check("ready_drop", {63'd0, ready_o}, 64'd0);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_m7_2", 64'(lat), 64'd33);
        check("res_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);

        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("res_max_1", res, 64'h00000000_FFFFFFFF);

        run_op(1'b0, 32'd5, 32'd0, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_u_5_0", 64'(lat), 64'd1);
        check("res_u_5_0", res, 64'h00000005_FFFFFFFF);
        run_op(1'b1, 32'd5, 32'd0, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_s_5_0", 64'(lat), 64'd1);
        check("res_s_5_0", res, 64'h00000005_FFFFFFFF);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_s_ovf", 64'(lat), 64'd1);
        check("res_s_ovf", res, 64'h00000000_80000000);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("lat_u_ovf", 64'(lat), 64'd33);
        check("res_u_ovf", res, 64'h80000000_00000000);

        run_op(1'b0, 32'd1000, 32'd7, 0, 10, -1, 1'b0, 1'b0, lat, res);
        check("annul_no_ready", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
        run_op(1'b0, 32'd9, 32'd3, 0, -1, -1, 1'b0, 1'b0, lat, res);
        check("res_9_3", res, 64'h00000000_00000003);

        run_op(1'b0, 32'd12345, 32'd67, 0, -1, 20, 1'b0, 1'b0, lat, res);
        check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check("rst_mid_result", result_o, 64'd0);

        run_op(1'b0, 32'd1000, 32'd10, 5, -1, -1, 1'b0, 1'b0, lat, res);
        check("res_hold5", res, 64'h00000000_00000064);
        run_op(1'b0, 32'd1000, 32'd10, 0, -1, -1, 1'b0, 1'b1, lat, res);
        check("res_chg_ops", res, 64'h00000000_00000064);
        run_op(1'b1, 32'hFFFF_FC18, 32'd10, 0, -1, -1, 1'b1, 1'b1, lat, res);
        check("res_drop_start", res, 64'h00000000_FFFFFF9C);

        for (int i = 0; i < 300; i++) begin
            int annul_at;
            annul_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : -1;
            run_op(1'($urandom_range(0, 1)), pick(), pick(), int'($urandom_range(0, 3)),
                   annul_at, -1, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), lat, res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
